// File: rtl/bunny_spawn_scheduler.sv
// Round sequencer for the bunny game: picks hole and pre-show delay from the LFSR, times each show, scores hits/misses.
// Optional build macro WRONG_HIT_PENALTY_EN: a wrong-hole press during a show also counts as a miss.
module bunny_spawn_scheduler #(
    parameter int NUM_HOLES  = 8,
    parameter int GAP_MIN    = 10,
    parameter int SHOW_TICKS = 50,
    parameter int MAX_ROUNDS = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 tick,
    input  logic [7:0]           random,
    input  logic                 hit_valid,
    input  logic [2:0]           hit_hole,
    output logic                 rnd_take,
    output logic [NUM_HOLES-1:0] bunny_on,
    output logic [7:0]           score,
    output logic [7:0]           miss_cnt,
    output logic [4:0]           round_no,
    output logic                 busy,
    output logic                 done
);

    localparam int SPAN   = (SHOW_TICKS > GAP_MIN + 15) ? SHOW_TICKS : GAP_MIN + 15;
    localparam int CW_RAW = $clog2(SPAN + 1);
    localparam int CW     = (CW_RAW > 9) ? CW_RAW : 9;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_DELAY = 3'd2,
        S_SHOW  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 state_r, state_n;
    logic [CW-1:0]          cnt_r, cnt_n;
    logic [2:0]             hole_r, hole_n;
    logic [2:0]             prev_hole_r, prev_hole_n;
    logic                   first_r, first_n;
    logic [7:0]             score_r, score_n;
    logic [7:0]             miss_r, miss_n;
    logic [4:0]             round_r, round_n;
    logic                   rnd_take_r, busy_r, done_r;
    logic [NUM_HOLES-1:0]   bunny_r, bunny_s;

    logic [2:0]             cand_s;
    logic [CW-1:0]          dly_s;
    logic                   hit_s, timeout_s, last_s;
    logic [4:0]             round_inc_s;
    logic                   unused_random_s;

    // Saturating 8-bit add of a small increment.
    function automatic logic [7:0] sat_add(input logic [7:0] val, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, val} + {7'd0, inc};
        if (sum[8]) begin
            sat_add = 8'hFF;
        end else begin
            sat_add = sum[7:0];
        end
    endfunction

    assign cand_s          = random[2:0];
    assign dly_s           = CW'(GAP_MIN) + CW'(random[7:4]);
    assign hit_s           = hit_valid && (hit_hole == hole_r);
    assign timeout_s       = tick && (cnt_r == CW'(1));
    assign round_inc_s     = round_r + 5'd1;
    assign last_s          = (round_inc_s == 5'(MAX_ROUNDS));
    assign unused_random_s = random[3];

`ifdef WRONG_HIT_PENALTY_EN
    logic wrong_s;
    assign wrong_s = hit_valid && (hit_hole != hole_r);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state and datapath decisions; the tick counter is reloaded on every transition.
    always_comb begin
        state_n     = state_r;
        cnt_n       = cnt_r;
        hole_n      = hole_r;
        prev_hole_n = prev_hole_r;
        first_n     = first_r;
        score_n     = score_r;
        miss_n      = miss_r;
        round_n     = round_r;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (start) begin
                    score_n = 8'd0;
                    miss_n  = 8'd0;
                    round_n = 5'd0;
                    first_n = 1'b1;
                    cnt_n   = {CW{1'b0}};
                    state_n = S_ARM;
                end else begin
                    state_n = state_r;
                end
            end
            S_ARM: begin
                // Never show the same hole twice in a row within a game.
                if (!first_r && (cand_s == prev_hole_r)) begin
                    hole_n = cand_s + 3'd1;
                end else begin
                    hole_n = cand_s;
                end
                prev_hole_n = hole_n;
                first_n     = 1'b0;
                cnt_n       = dly_s;
                state_n     = S_DELAY;
            end
            S_DELAY: begin
                if ((cnt_r == {CW{1'b0}}) || (tick && (cnt_r == CW'(1)))) begin
                    cnt_n   = CW'(SHOW_TICKS);
                    state_n = S_SHOW;
                end else if (tick) begin
                    cnt_n = cnt_r - CW'(1);
                end else begin
                    cnt_n = cnt_r;
                end
            end
            S_SHOW: begin
                if (hit_s) begin
                    score_n = sat_add(score_r, 2'd1);
                    round_n = round_inc_s;
                    cnt_n   = {CW{1'b0}};
                    state_n = last_s ? S_DONE : S_ARM;
                end else if (timeout_s) begin
`ifdef WRONG_HIT_PENALTY_EN
                    miss_n  = sat_add(miss_r, wrong_s ? 2'd2 : 2'd1);
`else
                    miss_n  = sat_add(miss_r, 2'd1);
`endif
                    round_n = round_inc_s;
                    cnt_n   = {CW{1'b0}};
                    state_n = last_s ? S_DONE : S_ARM;
                end else begin
`ifdef WRONG_HIT_PENALTY_EN
                    miss_n  = wrong_s ? sat_add(miss_r, 2'd1) : miss_r;
`endif
                    cnt_n   = tick ? (cnt_r - CW'(1)) : cnt_r;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign bunny_s = (state_n == S_SHOW) ? ({{(NUM_HOLES-1){1'b0}}, 1'b1} << hole_n)
                                         : {NUM_HOLES{1'b0}};

    // Datapath and output registers; outputs reflect the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r       <= {CW{1'b0}};
            hole_r      <= 3'd0;
            prev_hole_r <= 3'd0;
            first_r     <= 1'b1;
            score_r     <= 8'd0;
            miss_r      <= 8'd0;
            round_r     <= 5'd0;
            rnd_take_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            bunny_r     <= {NUM_HOLES{1'b0}};
        end else begin
            cnt_r       <= cnt_n;
            hole_r      <= hole_n;
            prev_hole_r <= prev_hole_n;
            first_r     <= first_n;
            score_r     <= score_n;
            miss_r      <= miss_n;
            round_r     <= round_n;
            rnd_take_r  <= (state_n == S_ARM);
            busy_r      <= (state_n == S_ARM) || (state_n == S_DELAY) || (state_n == S_SHOW);
            done_r      <= (state_n == S_DONE);
            bunny_r     <= bunny_s;
        end
    end

    assign rnd_take = rnd_take_r;
    assign bunny_on = bunny_r;
    assign score    = score_r;
    assign miss_cnt = miss_r;
    assign round_no = round_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_bunny_spawn_scheduler.sv
// Self-checking bench for bunny_spawn_scheduler: appearance scoreboard plus directed game checks.
module tb_bunny_spawn_scheduler;

`ifdef WRONG_HIT_PENALTY_EN
    localparam int PEN = 1;
`else
    localparam int PEN = 0;
`endif

    logic       clk;
    logic       reset;
    logic       start;
    logic       tick;
    logic [7:0] random;
    logic       hit_valid;
    logic [2:0] hit_hole;
    logic       rnd_take;
    logic [7:0] bunny_on;
    logic [7:0] score;
    logic [7:0] miss_cnt;
    logic [4:0] round_no;
    logic       busy;
    logic       done;

    typedef struct {
        logic [7:0] bunny;
        int         dly;
        int         show;
    } sb_t;

    sb_t        sb_q[$];
    sb_t        cur;
    int         checks_cnt = 0;
    int         errors_cnt = 0;
    logic [1:0] tphase = 2'd0;
    logic [7:0] prev_bunny = 8'd0;
    logic       prev_rnd = 1'b0;
    int         dtick = 0;
    int         stick = 0;

    bunny_spawn_scheduler #(
        .NUM_HOLES (8),
        .GAP_MIN   (2),
        .SHOW_TICKS(4),
        .MAX_ROUNDS(3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .tick     (tick),
        .random   (random),
        .hit_valid(hit_valid),
        .hit_hole (hit_hole),
        .rnd_take (rnd_take),
        .bunny_on (bunny_on),
        .score    (score),
        .miss_cnt (miss_cnt),
        .round_no (round_no),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Tracks delay/show tick counts and pops the scoreboard on each appearance.
    task automatic monitor(input logic seen_tick);
        if (prev_rnd) dtick = 0;
        else if (seen_tick) dtick++;
        if ((prev_bunny != 8'd0) && seen_tick) stick++;
        if ((bunny_on != 8'd0) && (prev_bunny == 8'd0)) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_show", bunny_on, 8'd0);
            end else begin
                cur = sb_q.pop_front();
                check("bunny_hole", bunny_on, cur.bunny);
                check("bunny_delay_ticks", dtick, cur.dly);
            end
            stick = 0;
        end
        if ((bunny_on == 8'd0) && (prev_bunny != 8'd0) && (cur.show >= 0))
            check("show_ticks", stick, cur.show);
        prev_bunny = bunny_on;
        prev_rnd   = rnd_take;
    endtask

    task automatic clk_step();
        logic seen;
        @(negedge clk);
        seen      = tick;
        monitor(seen);
        start     = 1'b0;
        hit_valid = 1'b0;
        tphase    = tphase + 2'd1;
        tick      = (tphase == 2'd3);
    endtask

    task automatic wait_bunny(input logic want, input string tag);
        int n = 0;
        while (((bunny_on != 8'd0) != want) && (n < 300)) begin
            clk_step();
            n++;
        end
        check(tag, (bunny_on != 8'd0), want);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cur.bunny = 8'd0; cur.dly = 0; cur.show = -1;
        reset = 1'b1; start = 1'b0; tick = 1'b0; random = 8'h00;
        hit_valid = 1'b0; hit_hole = 3'd0;
        clk_step();
        clk_step();
        reset = 1'b0;
        clk_step();
        check("rst_bunny", bunny_on, 8'd0);
        check("rst_score", score, 8'd0);
        check("rst_miss", miss_cnt, 8'd0);
        check("rst_round", round_no, 5'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rnd_take", rnd_take, 1'b0);

        // Game A: random held at 8'h35 -> hole 5, delay 2+3 ticks; repeat avoidance gives hole 6.
        random = 8'h35;
        sb_q.push_back('{8'h20, 5, -1});
        sb_q.push_back('{8'h40, 5, 4});
        sb_q.push_back('{8'h20, 5, 4});
        start = 1'b1;
        clk_step();
        check("a_rnd_take", rnd_take, 1'b1);
        check("a_busy", busy, 1'b1);
        check("a_done", done, 1'b0);
        clk_step();
        check("a_rnd_take_pulse", rnd_take, 1'b0);
        wait_bunny(1'b1, "a_r1_show");
        hit_valid = 1'b1; hit_hole = 3'd2;
        clk_step();
        check("a_wrong_miss", miss_cnt, 8'(PEN));
        check("a_wrong_bunny", bunny_on, 8'h20);
        check("a_wrong_round", round_no, 5'd0);
        check("a_wrong_score", score, 8'd0);
        hit_valid = 1'b1; hit_hole = 3'd5;
        clk_step();
        check("a_hit_score", score, 8'd1);
        check("a_hit_bunny_clr", bunny_on, 8'd0);
        check("a_hit_round", round_no, 5'd1);
        wait_bunny(1'b1, "a_r2_show");
        begin
            int n = 0;
            while (!(tick && (stick == 3)) && (n < 100)) begin
                clk_step();
                n++;
            end
            check("a_align_4th_tick", stick, 3);
        end
        hit_valid = 1'b1; hit_hole = 3'd6;
        clk_step();
        check("a_tie_score", score, 8'd2);
        check("a_tie_miss", miss_cnt, 8'(PEN));
        check("a_tie_round", round_no, 5'd2);
        wait_bunny(1'b1, "a_r3_show");
        wait_bunny(1'b0, "a_r3_timeout");
        check("a_end_miss", miss_cnt, 8'(PEN + 1));
        check("a_end_score", score, 8'd2);
        check("a_end_round", round_no, 5'd3);
        check("a_end_done", done, 1'b1);
        check("a_end_busy", busy, 1'b0);
        repeat (5) clk_step();
        check("a_hold_done", done, 1'b1);
        check("a_hold_round", round_no, 5'd3);

        // Game B: no hits; hole 7, then 7 repeated wraps to 0, then hole 2 with the longest delay.
        random = 8'h07;
        sb_q.push_back('{8'h80, 2, 4});
        sb_q.push_back('{8'h01, 2, 4});
        sb_q.push_back('{8'h04, 17, 4});
        start = 1'b1;
        clk_step();
        check("b_rnd_take", rnd_take, 1'b1);
        check("b_busy", busy, 1'b1);
        check("b_clr_score", score, 8'd0);
        check("b_clr_miss", miss_cnt, 8'd0);
        check("b_clr_round", round_no, 5'd0);
        clk_step();
        hit_valid = 1'b1; hit_hole = 3'd7;
        clk_step();
        for (int r = 1; r <= 3; r++) begin
            wait_bunny(1'b1, "b_show");
            if (r == 2) random = 8'hF2;
            wait_bunny(1'b0, "b_timeout");
            check("b_miss", miss_cnt, 8'(r));
            check("b_round", round_no, 5'(r));
            check("b_score", score, 8'd0);
        end
        check("b_done", done, 1'b1);
        check("b_busy_end", busy, 1'b0);

        // Game C: stray start while busy, then reset in the middle of a show.
        random = 8'h35;
        sb_q.push_back('{8'h20, 5, -1});
        start = 1'b1;
        clk_step();
        check("c_rnd_take", rnd_take, 1'b1);
        clk_step();
        start = 1'b1;
        clk_step();
        check("c_stray_start_rnd", rnd_take, 1'b0);
        check("c_stray_start_busy", busy, 1'b1);
        wait_bunny(1'b1, "c_show");
        reset = 1'b1;
        clk_step();
        reset = 1'b0;
        check("c_rst_bunny", bunny_on, 8'd0);
        check("c_rst_score", score, 8'd0);
        check("c_rst_miss", miss_cnt, 8'd0);
        check("c_rst_round", round_no, 5'd0);
        check("c_rst_busy", busy, 1'b0);
        check("c_rst_done", done, 1'b0);
        repeat (4) clk_step();
        check("c_idle_busy", busy, 1'b0);
        check("c_idle_rnd", rnd_take, 1'b0);
        check("c_idle_done", done, 1'b0);
        check("sb_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
